// File: rtl/alu_pkg.sv
// Shared ALU opcode and operand-select encodings for the RV32I pipeline.
// Imported by ex_operand_stage and fwd_mux.
package alu_pkg;

    localparam int DEF_XLEN = 32;
    localparam int DEF_RA_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_SLL   = 4'b0010,
        ALU_SLT   = 4'b0011,
        ALU_SLTU  = 4'b0100,
        ALU_XOR   = 4'b0101,
        ALU_SRL   = 4'b0110,
        ALU_SRA   = 4'b0111,
        ALU_OR    = 4'b1000,
        ALU_AND   = 4'b1001,
        ALU_PASSB = 4'b1111
    } alu_op_e;

    localparam logic [1:0] A_SEL_RS1  = 2'b00;
    localparam logic [1:0] A_SEL_PC   = 2'b01;
    localparam logic [1:0] A_SEL_ZERO = 2'b10;

    localparam logic B_SEL_RS2 = 1'b0;
    localparam logic B_SEL_IMM = 1'b1;

    // Shifts only consume the low five bits of operand B.
    function automatic logic is_shift(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Resolves one source operand: EX/MEM result beats MEM/WB data, which beats
// the registered read data. x0 always resolves to zero and is never forwarded.
module fwd_mux
    import alu_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int RA_W = DEF_RA_W
) (
    input  logic [RA_W-1:0] rs,
    input  logic [XLEN-1:0] reg_data,
    input  logic            exm_reg_we,
    input  logic [RA_W-1:0] exm_rd,
    input  logic [XLEN-1:0] exm_res,
    input  logic            wb_reg_we,
    input  logic [RA_W-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] data,
    output logic            fwd
);

    always_comb begin
        data = reg_data;
        fwd  = 1'b0;
        if (rs == '0) begin
            data = '0;
        end else if (exm_reg_we && (exm_rd == rs)) begin
            data = exm_res;
            fwd  = 1'b1;
        end else if (wb_reg_we && (wb_rd == rs)) begin
            data = wb_data;
            fwd  = 1'b1;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding and load-use bubble insertion.
// Optional performance counters are enabled with the EX_PERF_CNT_EN macro.
module ex_operand_stage
    import alu_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int RA_W = DEF_RA_W
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            id_valid_i,
    input  logic [XLEN-1:0] id_pc_i,
    input  logic [RA_W-1:0] id_rs1_i,
    input  logic [RA_W-1:0] id_rs2_i,
    input  logic [XLEN-1:0] id_rs1_data_i,
    input  logic [XLEN-1:0] id_rs2_data_i,
    input  logic [RA_W-1:0] id_rd_i,
    input  logic [XLEN-1:0] id_imm_i,
    input  logic [3:0]      id_alu_op_i,
    input  logic [1:0]      id_a_sel_i,
    input  logic            id_b_sel_i,
    input  logic            id_reg_we_i,
    input  logic            id_mem_rd_i,
    input  logic            id_mem_wr_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            exm_reg_we_i,
    input  logic [RA_W-1:0] exm_rd_i,
    input  logic [XLEN-1:0] exm_res_i,
    input  logic            wb_reg_we_i,
    input  logic [RA_W-1:0] wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic            load_use_stall_o,
    output logic            ex_valid_o,
    output logic [XLEN-1:0] alu_a_o,
    output logic [XLEN-1:0] alu_b_o,
    output logic [3:0]      alu_op_o,
    output logic [XLEN-1:0] ex_store_data_o,
    output logic [XLEN-1:0] ex_pc_o,
    output logic [RA_W-1:0] ex_rd_o,
    output logic            ex_reg_we_o,
    output logic            ex_mem_rd_o,
    output logic            ex_mem_wr_o
`ifdef EX_PERF_CNT_EN
   ,output logic [31:0]     perf_bubble_o,
    output logic [31:0]     perf_fwd_o
`endif
);

    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [RA_W-1:0] rs1_q;
    logic [RA_W-1:0] rs2_q;
    logic [XLEN-1:0] rs1_data_q;
    logic [XLEN-1:0] rs2_data_q;
    logic [RA_W-1:0] rd_q;
    logic [XLEN-1:0] imm_q;
    logic [3:0]      op_q;
    logic [1:0]      a_sel_q;
    logic            b_sel_q;
    logic            reg_we_q;
    logic            mem_rd_q;
    logic            mem_wr_q;

    logic [XLEN-1:0] rs1_res;
    logic [XLEN-1:0] rs2_res;
    logic            rs1_fwd;
    logic            rs2_fwd;
    logic [XLEN-1:0] b_raw;

    fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
        .rs         (rs1_q),
        .reg_data   (rs1_data_q),
        .exm_reg_we (exm_reg_we_i),
        .exm_rd     (exm_rd_i),
        .exm_res    (exm_res_i),
        .wb_reg_we  (wb_reg_we_i),
        .wb_rd      (wb_rd_i),
        .wb_data    (wb_data_i),
        .data       (rs1_res),
        .fwd        (rs1_fwd)
    );

    fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
        .rs         (rs2_q),
        .reg_data   (rs2_data_q),
        .exm_reg_we (exm_reg_we_i),
        .exm_rd     (exm_rd_i),
        .exm_res    (exm_res_i),
        .wb_reg_we  (wb_reg_we_i),
        .wb_rd      (wb_rd_i),
        .wb_data    (wb_data_i),
        .data       (rs2_res),
        .fwd        (rs2_fwd)
    );

    // Conservative: any source match against an in-flight load stalls, even if unused.
    assign load_use_stall_o = valid_q && mem_rd_q && (rd_q != '0) && id_valid_i &&
                              ((rd_q == id_rs1_i) || (rd_q == id_rs2_i));

    // A stall refreshes the operand registers so values retiring from WB are not lost.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            rd_q       <= '0;
            imm_q      <= '0;
            op_q       <= ALU_ADD;
            a_sel_q    <= A_SEL_RS1;
            b_sel_q    <= B_SEL_RS2;
            reg_we_q   <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
        end else if (flush_i) begin
            valid_q    <= 1'b0;
            reg_we_q   <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            op_q       <= ALU_ADD;
        end else if (stall_i) begin
            rs1_data_q <= rs1_res;
            rs2_data_q <= rs2_res;
        end else if (load_use_stall_o) begin
            valid_q    <= 1'b0;
            reg_we_q   <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            op_q       <= ALU_ADD;
        end else begin
            valid_q    <= id_valid_i;
            pc_q       <= id_pc_i;
            rs1_q      <= id_rs1_i;
            rs2_q      <= id_rs2_i;
            rs1_data_q <= id_rs1_data_i;
            rs2_data_q <= id_rs2_data_i;
            rd_q       <= id_rd_i;
            imm_q      <= id_imm_i;
            op_q       <= id_alu_op_i;
            a_sel_q    <= id_a_sel_i;
            b_sel_q    <= id_b_sel_i;
            reg_we_q   <= id_reg_we_i;
            mem_rd_q   <= id_mem_rd_i;
            mem_wr_q   <= id_mem_wr_i;
        end
    end

    always_comb begin
        case (a_sel_q)
            A_SEL_RS1: alu_a_o = rs1_res;
            A_SEL_PC:  alu_a_o = pc_q;
            default:   alu_a_o = '0;
        endcase
    end

    assign b_raw   = (b_sel_q == B_SEL_IMM) ? imm_q : rs2_res;
    assign alu_b_o = is_shift(op_q) ? {{(XLEN-5){1'b0}}, b_raw[4:0]} : b_raw;

    assign alu_op_o        = op_q;
    assign ex_store_data_o = rs2_res;
    assign ex_pc_o         = pc_q;
    assign ex_rd_o         = rd_q;
    assign ex_valid_o      = valid_q;
    assign ex_reg_we_o     = valid_q & reg_we_q;
    assign ex_mem_rd_o     = valid_q & mem_rd_q;
    assign ex_mem_wr_o     = valid_q & mem_wr_q;

`ifdef EX_PERF_CNT_EN
    logic [31:0] bubble_cnt_q;
    logic [31:0] fwd_cnt_q;

    // Bubble counter only ticks when the load-use bubble is actually inserted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bubble_cnt_q <= '0;
            fwd_cnt_q    <= '0;
        end else begin
            if (!flush_i && !stall_i && load_use_stall_o) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
            if (valid_q && !stall_i && (rs1_fwd || rs2_fwd)) begin
                fwd_cnt_q <= fwd_cnt_q + 32'd1;
            end
        end
    end

    assign perf_bubble_o = bubble_cnt_q;
    assign perf_fwd_o    = fwd_cnt_q;
`else
    logic unused_fwd;
    assign unused_fwd = rs1_fwd | rs2_fwd;
`endif

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: directed scenarios plus randomized
// traffic compared against a behavioural model of the EX slot.
module tb_ex_operand_stage;
    import alu_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        id_valid_i;
    logic [31:0] id_pc_i;
    logic [4:0]  id_rs1_i, id_rs2_i;
    logic [31:0] id_rs1_data_i, id_rs2_data_i;
    logic [4:0]  id_rd_i;
    logic [31:0] id_imm_i;
    logic [3:0]  id_alu_op_i;
    logic [1:0]  id_a_sel_i;
    logic        id_b_sel_i;
    logic        id_reg_we_i, id_mem_rd_i, id_mem_wr_i;
    logic        stall_i, flush_i;
    logic        exm_reg_we_i;
    logic [4:0]  exm_rd_i;
    logic [31:0] exm_res_i;
    logic        wb_reg_we_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic        load_use_stall_o;
    logic        ex_valid_o;
    logic [31:0] alu_a_o, alu_b_o;
    logic [3:0]  alu_op_o;
    logic [31:0] ex_store_data_o;
    logic [31:0] ex_pc_o;
    logic [4:0]  ex_rd_o;
    logic        ex_reg_we_o, ex_mem_rd_o, ex_mem_wr_o;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm;
        logic [3:0]  op;
        logic [1:0]  asel;
        logic        bsel, we, mrd, mwr;
    } slot_t;

    slot_t m;

    ex_operand_stage dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .id_valid_i       (id_valid_i),
        .id_pc_i          (id_pc_i),
        .id_rs1_i         (id_rs1_i),
        .id_rs2_i         (id_rs2_i),
        .id_rs1_data_i    (id_rs1_data_i),
        .id_rs2_data_i    (id_rs2_data_i),
        .id_rd_i          (id_rd_i),
        .id_imm_i         (id_imm_i),
        .id_alu_op_i      (id_alu_op_i),
        .id_a_sel_i       (id_a_sel_i),
        .id_b_sel_i       (id_b_sel_i),
        .id_reg_we_i      (id_reg_we_i),
        .id_mem_rd_i      (id_mem_rd_i),
        .id_mem_wr_i      (id_mem_wr_i),
        .stall_i          (stall_i),
        .flush_i          (flush_i),
        .exm_reg_we_i     (exm_reg_we_i),
        .exm_rd_i         (exm_rd_i),
        .exm_res_i        (exm_res_i),
        .wb_reg_we_i      (wb_reg_we_i),
        .wb_rd_i          (wb_rd_i),
        .wb_data_i        (wb_data_i),
        .load_use_stall_o (load_use_stall_o),
        .ex_valid_o       (ex_valid_o),
        .alu_a_o          (alu_a_o),
        .alu_b_o          (alu_b_o),
        .alu_op_o         (alu_op_o),
        .ex_store_data_o  (ex_store_data_o),
        .ex_pc_o          (ex_pc_o),
        .ex_rd_o          (ex_rd_o),
        .ex_reg_we_o      (ex_reg_we_o),
        .ex_mem_rd_o      (ex_mem_rd_o),
        .ex_mem_wr_o      (ex_mem_wr_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: value a source register holds as seen by EX right now.
    function automatic logic [31:0] resolve(input logic [4:0] rs, input logic [31:0] regval);
        if (rs == 5'd0) return 32'd0;
        if (exm_reg_we_i && exm_rd_i == rs) return exm_res_i;
        if (wb_reg_we_i && wb_rd_i == rs) return wb_data_i;
        return regval;
    endfunction

    function automatic logic exp_lu();
        return m.valid && m.mrd && m.rd != 5'd0 && id_valid_i &&
               (m.rd == id_rs1_i || m.rd == id_rs2_i);
    endfunction

    function automatic logic [31:0] exp_a();
        if (m.asel == 2'd0) return resolve(m.rs1, m.d1);
        if (m.asel == 2'd1) return m.pc;
        return 32'd0;
    endfunction

    function automatic logic [31:0] exp_b();
        logic [31:0] b;
        b = m.bsel ? m.imm : resolve(m.rs2, m.d2);
        if (m.op == 4'd2 || m.op == 4'd6 || m.op == 4'd7) b = b % 32;
        return b;
    endfunction

    function automatic slot_t next_slot();
        slot_t n;
        n = m;
        if (rst_i) begin
            n = '{default: '0};
        end else if (flush_i || (!stall_i && exp_lu())) begin
            n.valid = 1'b0; n.we = 1'b0; n.mrd = 1'b0; n.mwr = 1'b0; n.op = 4'd0;
        end else if (stall_i) begin
            n.d1 = resolve(m.rs1, m.d1);
            n.d2 = resolve(m.rs2, m.d2);
        end else begin
            n.valid = id_valid_i; n.pc = id_pc_i; n.rs1 = id_rs1_i; n.rs2 = id_rs2_i;
            n.rd = id_rd_i; n.d1 = id_rs1_data_i; n.d2 = id_rs2_data_i; n.imm = id_imm_i;
            n.op = id_alu_op_i; n.asel = id_a_sel_i; n.bsel = id_b_sel_i;
            n.we = id_reg_we_i; n.mrd = id_mem_rd_i; n.mwr = id_mem_wr_i;
        end
        return n;
    endfunction

    task automatic step();
        slot_t n;
        n = next_slot();
        @(posedge clk_i);
        #1;
        m = n;
    endtask

    task automatic idle();
        rst_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        id_valid_i = 1'b0; id_pc_i = '0; id_rs1_i = '0; id_rs2_i = '0;
        id_rs1_data_i = '0; id_rs2_data_i = '0; id_rd_i = '0; id_imm_i = '0;
        id_alu_op_i = '0; id_a_sel_i = '0; id_b_sel_i = 1'b0;
        id_reg_we_i = 1'b0; id_mem_rd_i = 1'b0; id_mem_wr_i = 1'b0;
        exm_reg_we_i = 1'b0; exm_rd_i = '0; exm_res_i = '0;
        wb_reg_we_i = 1'b0; wb_rd_i = '0; wb_data_i = '0;
    endtask

    task automatic drive_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [31:0] d1, input logic [31:0] d2,
                            input logic [4:0] rd, input logic [31:0] imm, input logic [3:0] op,
                            input logic [1:0] asel, input logic bsel, input logic we,
                            input logic mrd, input logic mwr);
        id_valid_i = v; id_pc_i = pc; id_rs1_i = rs1; id_rs2_i = rs2;
        id_rs1_data_i = d1; id_rs2_data_i = d2; id_rd_i = rd; id_imm_i = imm;
        id_alu_op_i = op; id_a_sel_i = asel; id_b_sel_i = bsel;
        id_reg_we_i = we; id_mem_rd_i = mrd; id_mem_wr_i = mwr;
    endtask

    task automatic test_reset();
        idle();
        drive_id(1'b1, 32'h40, 5'd1, 5'd2, 32'hA, 32'hB, 5'd3, 32'h4, ALU_SUB,
                 A_SEL_PC, B_SEL_IMM, 1'b1, 1'b1, 1'b0);
        step();
        vectors++;
        if (ex_valid_o !== 1'b1) begin
            miscompares++; $display("[TB] FAIL reset_pre_valid got %b exp 1", ex_valid_o);
        end
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        #1;
        vectors++;
        if ({ex_valid_o, ex_reg_we_o, ex_mem_rd_o, ex_mem_wr_o, load_use_stall_o} !== 5'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl got %b exp 00000",
                     {ex_valid_o, ex_reg_we_o, ex_mem_rd_o, ex_mem_wr_o, load_use_stall_o});
        end
        vectors++;
        if ({alu_a_o, alu_b_o, ex_store_data_o, ex_pc_o} !== 128'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_data got a=%h b=%h st=%h pc=%h exp all 0",
                     alu_a_o, alu_b_o, ex_store_data_o, ex_pc_o);
        end
        vectors++;
        if ({alu_op_o, ex_rd_o} !== 9'd0) begin
            miscompares++; $display("[TB] FAIL reset_op_rd got op=%h rd=%0d exp 0", alu_op_o, ex_rd_o);
        end
    endtask

    task automatic test_fwd_priority();
        idle(); step();
        drive_id(1'b1, 32'h0, 5'd5, 5'd0, 32'h55, 32'h0, 5'd6, 32'h0, ALU_ADD,
                 A_SEL_RS1, B_SEL_RS2, 1'b1, 1'b0, 1'b0);
        step();
        id_valid_i = 1'b0;
        exm_reg_we_i = 1'b1; exm_rd_i = 5'd5; exm_res_i = 32'h11;
        wb_reg_we_i = 1'b1; wb_rd_i = 5'd5; wb_data_i = 32'h22;
        #1; vectors++;
        if (alu_a_o !== 32'h11) begin
            miscompares++; $display("[TB] FAIL fwd_exm_over_wb got %h exp 00000011", alu_a_o);
        end
        exm_reg_we_i = 1'b0;
        #1; vectors++;
        if (alu_a_o !== 32'h22) begin
            miscompares++; $display("[TB] FAIL fwd_wb got %h exp 00000022", alu_a_o);
        end
        wb_reg_we_i = 1'b0;
        #1; vectors++;
        if (alu_a_o !== 32'h55) begin
            miscompares++; $display("[TB] FAIL fwd_none got %h exp 00000055", alu_a_o);
        end
        drive_id(1'b1, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 5'd6, 32'h0, ALU_ADD,
                 A_SEL_RS1, B_SEL_RS2, 1'b1, 1'b0, 1'b0);
        step();
        id_valid_i = 1'b0;
        exm_reg_we_i = 1'b1; exm_rd_i = 5'd0; exm_res_i = 32'h11;
        wb_reg_we_i = 1'b1; wb_rd_i = 5'd0; wb_data_i = 32'h22;
        #1; vectors++;
        if (alu_a_o !== 32'h0 || ex_store_data_o !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL fwd_x0 got a=%h st=%h exp 0", alu_a_o, ex_store_data_o);
        end
        idle();
    endtask

    task automatic test_load_use();
        idle(); step();
        drive_id(1'b1, 32'h200, 5'd1, 5'd0, 32'h1000, 32'h0, 5'd7, 32'h8, ALU_ADD,
                 A_SEL_RS1, B_SEL_IMM, 1'b1, 1'b1, 1'b0);
        step();
        drive_id(1'b1, 32'h204, 5'd2, 5'd7, 32'h3, 32'h0, 5'd3, 32'h0, ALU_ADD,
                 A_SEL_RS1, B_SEL_RS2, 1'b1, 1'b0, 1'b0);
        #1; vectors++;
        if (load_use_stall_o !== 1'b1) begin
            miscompares++; $display("[TB] FAIL lu_detect got %b exp 1", load_use_stall_o);
        end
        step();
        vectors++;
        if (ex_valid_o !== 1'b0 || ex_reg_we_o !== 1'b0 || ex_mem_rd_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL lu_bubble got v=%b we=%b rd=%b exp 0", ex_valid_o, ex_reg_we_o, ex_mem_rd_o);
        end
        vectors++;
        if (load_use_stall_o !== 1'b0) begin
            miscompares++; $display("[TB] FAIL lu_release got %b exp 0", load_use_stall_o);
        end
        step();
        wb_reg_we_i = 1'b1; wb_rd_i = 5'd7; wb_data_i = 32'hDEAD;
        #1; vectors++;
        if (ex_valid_o !== 1'b1 || alu_b_o !== 32'hDEAD || ex_pc_o !== 32'h204) begin
            miscompares++;
            $display("[TB] FAIL lu_forward got v=%b b=%h pc=%h exp 1 0000dead 00000204",
                     ex_valid_o, alu_b_o, ex_pc_o);
        end
        idle();
    endtask

    task automatic test_stall_retention();
        idle(); step();
        drive_id(1'b1, 32'h300, 5'd9, 5'd0, 32'h1111, 32'h0, 5'd4, 32'h0, ALU_XOR,
                 A_SEL_RS1, B_SEL_RS2, 1'b1, 1'b0, 1'b0);
        step();
        id_valid_i = 1'b0;
        stall_i = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            wb_reg_we_i = (c == 1); wb_rd_i = 5'd9; wb_data_i = 32'hCAFE;
            #1; vectors++;
            if (alu_a_o !== 32'hCAFE) begin
                miscompares++; $display("[TB] FAIL stall_keep cycle %0d got %h exp 0000cafe", c, alu_a_o);
            end
            step();
        end
        stall_i = 1'b0; wb_reg_we_i = 1'b0;
        #1; vectors++;
        if (alu_a_o !== 32'hCAFE || ex_valid_o !== 1'b1) begin
            miscompares++; $display("[TB] FAIL stall_after got a=%h v=%b exp 0000cafe 1", alu_a_o, ex_valid_o);
        end
        idle();
    endtask

    task automatic test_flush_beats_stall();
        idle(); step();
        drive_id(1'b1, 32'h400, 5'd1, 5'd2, 32'h1, 32'h2, 5'd5, 32'h0, ALU_OR,
                 A_SEL_RS1, B_SEL_RS2, 1'b1, 1'b0, 1'b1);
        step();
        flush_i = 1'b1; stall_i = 1'b1;
        step();
        flush_i = 1'b0; stall_i = 1'b0; id_valid_i = 1'b0;
        vectors++;
        if (ex_valid_o !== 1'b0 || ex_reg_we_o !== 1'b0 || ex_mem_wr_o !== 1'b0 || alu_op_o !== 4'd0) begin
            miscompares++;
            $display("[TB] FAIL flush_over_stall got v=%b we=%b wr=%b op=%h exp 0 0 0 0",
                     ex_valid_o, ex_reg_we_o, ex_mem_wr_o, alu_op_o);
        end
        idle();
    endtask

    task automatic test_imm_shift();
        idle(); step();
        drive_id(1'b1, 32'h500, 5'd1, 5'd0, 32'h9, 32'h0, 5'd2, 32'h23, ALU_SLL,
                 A_SEL_RS1, B_SEL_IMM, 1'b1, 1'b0, 1'b0);
        step();
        drive_id(1'b1, 32'h504, 5'd0, 5'd0, 32'h0, 32'h0, 5'd3, 32'h12345000, ALU_PASSB,
                 A_SEL_ZERO, B_SEL_IMM, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (alu_b_o !== 32'd3 || alu_op_o !== 4'b0010) begin
            miscompares++; $display("[TB] FAIL shift_mask got b=%h op=%h exp 00000003 2", alu_b_o, alu_op_o);
        end
        step();
        drive_id(1'b1, 32'h100, 5'd0, 5'd0, 32'h0, 32'h0, 5'd4, 32'h1000, ALU_ADD,
                 A_SEL_PC, B_SEL_IMM, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (alu_b_o !== 32'h12345000 || alu_a_o !== 32'd0) begin
            miscompares++; $display("[TB] FAIL lui got a=%h b=%h exp 0 12345000", alu_a_o, alu_b_o);
        end
        step();
        id_valid_i = 1'b0;
        vectors++;
        if (alu_a_o !== 32'h100 || alu_b_o !== 32'h1000) begin
            miscompares++; $display("[TB] FAIL auipc got a=%h b=%h exp 00000100 00001000", alu_a_o, alu_b_o);
        end
        idle();
    endtask

    task automatic test_random();
        idle(); step();
        for (int cyc = 0; cyc < 400; cyc++) begin
            id_valid_i    = ($urandom_range(3) != 0);
            id_pc_i       = $urandom;
            id_rs1_i      = 5'($urandom_range(7));
            id_rs2_i      = 5'($urandom_range(7));
            id_rs1_data_i = $urandom;
            id_rs2_data_i = $urandom;
            id_rd_i       = 5'($urandom_range(7));
            id_imm_i      = $urandom;
            id_alu_op_i   = 4'($urandom_range(15));
            id_a_sel_i    = 2'($urandom_range(3));
            id_b_sel_i    = 1'($urandom_range(1));
            id_reg_we_i   = 1'($urandom_range(1));
            id_mem_rd_i   = ($urandom_range(2) == 0);
            id_mem_wr_i   = ($urandom_range(3) == 0);
            stall_i       = ($urandom_range(6) == 0);
            flush_i       = ($urandom_range(9) == 0);
            exm_reg_we_i  = 1'($urandom_range(1));
            exm_rd_i      = 5'($urandom_range(7));
            exm_res_i     = $urandom;
            wb_reg_we_i   = 1'($urandom_range(1));
            wb_rd_i       = 5'($urandom_range(7));
            wb_data_i     = $urandom;
            #1;
            vectors++;
            if (load_use_stall_o !== exp_lu()) begin
                miscompares++; $display("[TB] FAIL rand_lu cyc %0d got %b exp %b", cyc, load_use_stall_o, exp_lu());
            end
            vectors++;
            if ({ex_valid_o, ex_reg_we_o, ex_mem_rd_o, ex_mem_wr_o} !==
                {m.valid, m.valid & m.we, m.valid & m.mrd, m.valid & m.mwr}) begin
                miscompares++;
                $display("[TB] FAIL rand_ctrl cyc %0d got %b exp %b", cyc,
                         {ex_valid_o, ex_reg_we_o, ex_mem_rd_o, ex_mem_wr_o},
                         {m.valid, m.valid & m.we, m.valid & m.mrd, m.valid & m.mwr});
            end
            vectors++;
            if (alu_op_o !== m.op) begin
                miscompares++; $display("[TB] FAIL rand_op cyc %0d got %h exp %h", cyc, alu_op_o, m.op);
            end
            if (m.valid) begin
                vectors++;
                if (alu_a_o !== exp_a() || alu_b_o !== exp_b()) begin
                    miscompares++;
                    $display("[TB] FAIL rand_alu cyc %0d got a=%h b=%h exp a=%h b=%h",
                             cyc, alu_a_o, alu_b_o, exp_a(), exp_b());
                end
                vectors++;
                if (ex_store_data_o !== resolve(m.rs2, m.d2) || ex_pc_o !== m.pc || ex_rd_o !== m.rd) begin
                    miscompares++;
                    $display("[TB] FAIL rand_pass cyc %0d got st=%h pc=%h rd=%0d exp st=%h pc=%h rd=%0d",
                             cyc, ex_store_data_o, ex_pc_o, ex_rd_o, resolve(m.rs2, m.d2), m.pc, m.rd);
                end
            end
            step();
        end
        idle();
    endtask

    initial begin
        m = '{default: '0};
        idle();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        test_reset();
        test_fwd_priority();
        test_load_use();
        test_stall_retention();
        test_flush_beats_stall();
        test_imm_shift();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register plus operand-resolution logic for the RV32I 5-stage pipeline.
- Captures decoded instructions from ID and resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards and inserts bubbles.
- Drives the ALU inputs (operand A, operand B, 4-bit opcode) and the EX-stage control and store data consumed by the MEM stage.

Parameters:
- XLEN, 32, datapath width
- RA_W, 5, register-address width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- id_valid_i  in  1  ID slot holds a real instruction
- id_pc_i  in  XLEN  instruction PC
- id_rs1_i, id_rs2_i  in  RA_W  source register indices
- id_rs1_data_i, id_rs2_data_i  in  XLEN  register-file read data
- id_rd_i  in  RA_W  destination register
- id_imm_i  in  XLEN  sign-extended immediate
- id_alu_op_i  in  4  ALU opcode
- id_a_sel_i  in  2  operand A select: 00 rs1, 01 PC, 10 zero
- id_b_sel_i  in  1  operand B select: 0 rs2, 1 imm
- id_reg_we_i, id_mem_rd_i, id_mem_wr_i  in  1 each  control bits
- stall_i  in  1  downstream hold request
- flush_i  in  1  kill the instruction entering EX (taken branch/jump)
- exm_reg_we_i  in  1  EX/MEM write enable
- exm_rd_i  in  RA_W  EX/MEM destination
- exm_res_i  in  XLEN  EX/MEM result
- wb_reg_we_i  in  1  MEM/WB write enable
- wb_rd_i  in  RA_W  MEM/WB destination
- wb_data_i  in  XLEN  MEM/WB data
- load_use_stall_o  out  1  combinational; freeze IF/ID
- ex_valid_o  out  1  EX slot valid
- alu_a_o, alu_b_o  out  XLEN  ALU operands
- alu_op_o  out  4  ALU opcode
- ex_store_data_o  out  XLEN  forwarded rs2 data, for stores
- ex_pc_o  out  XLEN  EX PC
- ex_rd_o  out  RA_W  EX destination
- ex_reg_we_o, ex_mem_rd_o, ex_mem_wr_o  out  1 each  EX control

Behaviour:
- Reset: on a clk_i edge with rst_i=1, all registers clear. ex_valid_o, controls, rd, pc, op and data all become 0.
- Latency: 1 cycle from ID capture to EX outputs. Forwarding muxes are combinational on registered state.
- Per-cycle update priority: rst_i > flush_i > stall_i > load_use_stall_o > normal load.
  - flush_i: load a bubble (valid=0, reg_we/mem_rd/mem_wr=0, op=0000); other fields don't-care.
  - stall_i: hold all fields, but rewrite rs1/rs2 data registers with their forwarded values each stalled cycle. This keeps values that retire from MEM/WB during the stall.
  - load_use_stall_o=1 (and no stall_i/flush_i): load a bubble. Upstream holds ID.
  - Normal: capture all id_* inputs; valid=id_valid_i.
- Load-use detection: load_use_stall_o = ex_valid & ex_mem_rd & ex_rd≠0 & id_valid_i & (ex_rd==id_rs1_i | ex_rd==id_rs2_i). Detection is conservative: no per-operand use decode.
- Forwarding, per source rs, with rs≠0 required:
  - If exm_reg_we_i & exm_rd_i==rs, use exm_res_i.
  - Else if wb_reg_we_i & wb_rd_i==rs, use wb_data_i.
  - Else use the registered data.
  - EX/MEM beats WB. x0 always reads 0 and is never forwarded.
- alu_a_o: resolved rs1, PC, or 0, per a_sel. Encoding 11 gives 0.
- alu_b_o: resolved rs2, or imm.
- Shift masking: for op SLL/SRL/SRA, alu_b_o = {27'b0, b[4:0]}.
- Passthrough: ex_store_data_o = resolved rs2, always, independent of b_sel. alu_op_o passes through unchanged.
- Bubbles: while ex_valid_o=0, all control outputs are 0.

Optional Feature:
- Macro: EX_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_bubble_o[31:0], incremented on every load-use bubble insertion.
  - Adds perf_fwd_o[31:0], incremented once per valid, non-stalled EX cycle in which either operand was forwarded.
  - Both counters wrap at 2^32 and clear on rst_i.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package alu_pkg holds:
  - ALU opcode constants: ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001, PASSB 1111.
  - A_SEL_RS1/PC/ZERO and B_SEL_RS2/IMM.
  - XLEN and RA_W defaults.
- Sub-module fwd_mux: resolves one operand (rs index, reg data, EX/MEM and WB buses). Instantiated twice.

Test Plan:
- Reset mid-stream: rst_i=1 for 1 cycle while ex_valid=1 -> next cycle ex_valid_o=0, all outputs 0, load_use_stall_o=0.
- EX/MEM vs WB priority: EX holds rs1=5; exm(we=1,rd=5,res=0x11) and wb(we=1,rd=5,data=0x22) -> alu_a_o=0x11. Drop exm_reg_we_i -> 0x22. With rs1=0 and the same buses -> 0.
- Load-use: EX=lw x7 (mem_rd=1), ID add rs2=7 -> load_use_stall_o=1. Next cycle ex_valid_o=0 and the add is still in ID. Following cycle the add loads, and wb rd=7 data=0xDEAD forwards to alu_b_o.
- Stall retention: stall_i=1 for 3 cycles; WB forwards rs1=0xCAFE only in cycle 1 -> alu_a_o stays 0xCAFE through cycles 2-3.
- Flush beats stall: flush_i=1, stall_i=1 simultaneously -> next cycle ex_valid_o=0, ex_reg_we_o=0.
- Immediate/shift/LUI: SLL with imm=0x0000_0023 -> alu_b_o=3. LUI op=1111, b_sel=imm=0x12345000 -> alu_b_o=0x12345000. AUIPC a_sel=PC=0x100 -> alu_a_o=0x100.
